bmp_stream_loader: RTL and testbench

BMP_STREAM_LOADER -- requirements
Module: bmp_stream_loader

---
 rtl/bmp_stream_loader_pkg.sv | 36 +++
 rtl/bmp_hdr_parser.sv | 108 ++++++++++
 rtl/bmp_stream_loader.sv | 184 ++++++++++++++++++
 tb/tb_bmp_stream_loader.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmp_stream_loader_pkg.sv
// rtl/bmp_stream_loader_pkg.sv - shared states, error codes and BMP header byte offsets
package bmp_stream_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_SKIP,
        ST_PIXEL,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_SIG     = 3'd1;
    localparam logic [2:0] ERR_WIDTH   = 3'd2;
    localparam logic [2:0] ERR_HEIGHT  = 3'd3;
    localparam logic [2:0] ERR_BPP     = 3'd4;
    localparam logic [2:0] ERR_OFFSET  = 3'd5;
    localparam logic [2:0] ERR_OVERRUN = 3'd6;
    localparam logic [2:0] ERR_TRUNC   = 3'd7;

    localparam logic [4:0] HDR_OFF_POS = 5'd10;
    localparam logic [4:0] HDR_W_POS   = 5'd18;
    localparam logic [4:0] HDR_H_POS   = 5'd22;
    localparam logic [4:0] HDR_BPP_POS = 5'd28;
    localparam logic [4:0] HDR_H_LAST  = 5'd25;
    localparam logic [4:0] HDR_LAST    = 5'd29;

    localparam logic [15:0] BMP_SIG    = 16'h4D42;
    localparam logic [31:0] MIN_OFFSET = 32'd30;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/bmp_hdr_parser.sv
// rtl/bmp_hdr_parser.sv - captures little-endian BMP header fields and validates them
// Optional feature: BMP_STREAM_LOADER_ALPHA_EN admits 32 bpp files.
module bmp_hdr_parser
    import bmp_stream_loader_pkg::*;
#(
    parameter int MAX_W = 512,
    parameter int MAX_H = 312
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        capture_i,
    input  logic [4:0]  addr_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] offset_o,
    output logic [15:0] width_o,
    output logic [15:0] height_o,
    output logic        height_neg_o,
    output logic [15:0] bpp_o,
    output logic        valid_o,
    output logic [2:0]  errcode_o
);

    logic [15:0] sig_q, sig_d;
    logic [31:0] off_q, off_d;
    logic [31:0] w_q, w_d;
    logic [31:0] h_q, h_d;
    logic [15:0] bpp_q, bpp_d;
    logic [31:0] abs_h;
    logic        bpp_ok;

    // Outputs are the next-state view so the byte being accepted is already visible.
    always_comb begin
        sig_d = sig_q;
        off_d = off_q;
        w_d   = w_q;
        h_d   = h_q;
        bpp_d = bpp_q;
        if (capture_i) begin
            case (addr_i)
                5'd0:                 sig_d[7:0]    = byte_i;
                5'd1:                 sig_d[15:8]   = byte_i;
                HDR_OFF_POS:          off_d[7:0]    = byte_i;
                HDR_OFF_POS + 5'd1:   off_d[15:8]   = byte_i;
                HDR_OFF_POS + 5'd2:   off_d[23:16]  = byte_i;
                HDR_OFF_POS + 5'd3:   off_d[31:24]  = byte_i;
                HDR_W_POS:            w_d[7:0]      = byte_i;
                HDR_W_POS + 5'd1:     w_d[15:8]     = byte_i;
                HDR_W_POS + 5'd2:     w_d[23:16]    = byte_i;
                HDR_W_POS + 5'd3:     w_d[31:24]    = byte_i;
                HDR_H_POS:            h_d[7:0]      = byte_i;
                HDR_H_POS + 5'd1:     h_d[15:8]     = byte_i;
                HDR_H_POS + 5'd2:     h_d[23:16]    = byte_i;
                HDR_H_POS + 5'd3:     h_d[31:24]    = byte_i;
                HDR_BPP_POS:          bpp_d[7:0]    = byte_i;
                HDR_BPP_POS + 5'd1:   bpp_d[15:8]   = byte_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q <= '0;
            off_q <= '0;
            w_q   <= '0;
            h_q   <= '0;
            bpp_q <= '0;
        end else if (clear_i) begin
            sig_q <= '0;
            off_q <= '0;
            w_q   <= '0;
            h_q   <= '0;
            bpp_q <= '0;
        end else begin
            sig_q <= sig_d;
            off_q <= off_d;
            w_q   <= w_d;
            h_q   <= h_d;
            bpp_q <= bpp_d;
        end
    end

    assign abs_h = abs32(h_d);

`ifdef BMP_STREAM_LOADER_ALPHA_EN
    assign bpp_ok = (bpp_d == 16'd24) || (bpp_d == 16'd32);
`else
    assign bpp_ok = (bpp_d == 16'd24);
`endif

    always_comb begin
        errcode_o = ERR_NONE;
        if (sig_d != BMP_SIG)                             errcode_o = ERR_SIG;
        else if ((w_d == 32'd0) || (w_d > 32'(MAX_W)))    errcode_o = ERR_WIDTH;
        else if ((abs_h == 32'd0) || (abs_h > 32'(MAX_H))) errcode_o = ERR_HEIGHT;
        else if (!bpp_ok)                                 errcode_o = ERR_BPP;
        else if (off_d < MIN_OFFSET)                      errcode_o = ERR_OFFSET;
    end

    assign valid_o      = (errcode_o == ERR_NONE);
    assign offset_o     = off_d;
    assign width_o      = w_d[15:0];
    assign height_o     = abs_h[15:0];
    assign height_neg_o = h_d[31];
    assign bpp_o        = bpp_d;

endmodule

// File: rtl/bmp_stream_loader.sv
// rtl/bmp_stream_loader.sv - streams a BMP download into 32-bit SDRAM pixel writes
// Optional feature: BMP_STREAM_LOADER_ALPHA_EN enables 32 bpp (alpha) files.
module bmp_stream_loader
    import bmp_stream_loader_pkg::*;
#(
    parameter int ADDR_W      = 22,
    parameter int STRIDE_LOG2 = 9,
    parameter int MAX_W       = 512,
    parameter int MAX_H       = 312
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              wr_req,
    input  logic              wr_ack,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              loaded,
    output logic [15:0]       img_w,
    output logic [15:0]       img_h,
    output logic [2:0]        err
);

    state_t            state_q;
    logic              wr_q, dl_q, armed_q;
    logic              wr_req_q, loaded_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic [15:0]       img_w_q, img_h_q;
    logic [2:0]        err_q;
    logic [15:0]       row_q, col_q;
    logic [1:0]        bidx_q, pad_q;
    logic [23:0]       pix_q;

    logic              dl_rise, dl_fall, byte_stb, pending, hdr_capture;
    logic [31:0]       hdr_offset;
    logic [15:0]       hdr_w, hdr_h, hdr_bpp;
    logic              hdr_neg, hdr_valid;
    logic [2:0]        hdr_err;
    logic              is32, last_byte, last_col, last_row;
    logic [1:0]        last_idx, pad_bytes;
    logic [15:0]       line;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       word_d, addr_ext;

    // armed_q blocks a false restart when download is still high as reset releases.
    assign dl_rise     = ioctl_download & ~dl_q & armed_q;
    assign dl_fall     = ~ioctl_download & dl_q;
    assign byte_stb    = ioctl_download & ioctl_wr & ~wr_q;
    assign pending     = wr_req_q ^ wr_ack;
    assign hdr_capture = byte_stb & (state_q == ST_HEADER) & ~dl_rise;

    bmp_hdr_parser #(
        .MAX_W (MAX_W),
        .MAX_H (MAX_H)
    ) u_hdr (
        .clk_i        (clk_sys),
        .rst_i        (reset),
        .clear_i      (dl_rise),
        .capture_i    (hdr_capture),
        .addr_i       (ioctl_addr[4:0]),
        .byte_i       (ioctl_dout),
        .offset_o     (hdr_offset),
        .width_o      (hdr_w),
        .height_o     (hdr_h),
        .height_neg_o (hdr_neg),
        .bpp_o        (hdr_bpp),
        .valid_o      (hdr_valid),
        .errcode_o    (hdr_err)
    );

    // 32 bpp can only get past the parser when the alpha feature is built in.
    assign is32      = (hdr_bpp == 16'd32);
    assign last_idx  = is32 ? 2'd3 : 2'd2;
    assign pad_bytes = is32 ? 2'd0 : hdr_w[1:0];
    assign last_byte = (bidx_q == last_idx);
    assign last_col  = (col_q == hdr_w - 16'd1);
    assign last_row  = (row_q == hdr_h - 16'd1);
    assign line      = hdr_neg ? row_q : (hdr_h - 16'd1 - row_q);
    assign addr_d    = (ADDR_W'(line) << STRIDE_LOG2) + ADDR_W'(col_q);
    assign word_d    = is32 ? {ioctl_dout, pix_q} : {8'h00, ioctl_dout, pix_q[15:0]};
    assign addr_ext  = {7'd0, ioctl_addr};

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wr_q      <= 1'b0;
            dl_q      <= 1'b0;
            armed_q   <= 1'b0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            loaded_q  <= 1'b0;
            img_w_q   <= '0;
            img_h_q   <= '0;
            err_q     <= ERR_NONE;
            row_q     <= '0;
            col_q     <= '0;
            bidx_q    <= '0;
            pad_q     <= '0;
            pix_q     <= '0;
        end else begin
            wr_q <= ioctl_wr;
            dl_q <= ioctl_download;
            if (!ioctl_download) armed_q <= 1'b1;

            if (dl_rise) begin
                state_q  <= ST_HEADER;
                loaded_q <= 1'b0;
                err_q    <= ERR_NONE;
                row_q    <= '0;
                col_q    <= '0;
                bidx_q   <= '0;
                pad_q    <= '0;
            end else if (dl_fall && (state_q == ST_HEADER || state_q == ST_SKIP
                                     || state_q == ST_PIXEL)) begin
                err_q   <= ERR_TRUNC;
                state_q <= ST_ERROR;
            end else begin
                case (state_q)
                    ST_HEADER: if (byte_stb) begin
                        if (ioctl_addr == {20'd0, HDR_H_LAST}) begin
                            img_w_q <= hdr_w;
                            img_h_q <= hdr_h;
                        end
                        if (ioctl_addr == {20'd0, HDR_LAST}) begin
                            if (!hdr_valid) begin
                                err_q   <= hdr_err;
                                state_q <= ST_ERROR;
                            end else if (addr_ext + 32'd1 == hdr_offset) begin
                                state_q <= ST_PIXEL;
                            end else begin
                                state_q <= ST_SKIP;
                            end
                        end
                    end
                    ST_SKIP: if (byte_stb && addr_ext == hdr_offset - 32'd1) begin
                        state_q <= ST_PIXEL;
                    end
                    ST_PIXEL: if (byte_stb) begin
                        if (pad_q != 2'd0) begin
                            pad_q <= pad_q - 2'd1;
                        end else if (!last_byte) begin
                            pix_q[{bidx_q, 3'b000} +: 8] <= ioctl_dout;
                            bidx_q <= bidx_q + 2'd1;
                        end else begin
                            bidx_q <= '0;
                            if (pending) begin
                                err_q   <= ERR_OVERRUN;
                                state_q <= ST_ERROR;
                            end else begin
                                wr_addr_q <= addr_d;
                                wr_data_q <= word_d;
                                wr_req_q  <= ~wr_req_q;
                                if (last_col) begin
                                    col_q <= '0;
                                    row_q <= row_q + 16'd1;
                                    pad_q <= pad_bytes;
                                    if (last_row) state_q <= ST_DONE;
                                end else begin
                                    col_q <= col_q + 16'd1;
                                end
                            end
                        end
                    end
                    ST_DONE: if (!pending) loaded_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign wr_req  = wr_req_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign loaded  = loaded_q;
    assign img_w   = img_w_q;
    assign img_h   = img_h_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bmp_stream_loader.sv
// tb/tb_bmp_stream_loader.sv - scoreboard bench for bmp_stream_loader
module tb_bmp_stream_loader;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        wr_req;
    logic        wr_ack = 1'b0;
    logic [21:0] wr_addr;
    logic [31:0] wr_data;
    logic        loaded;
    logic [15:0] img_w, img_h;
    logic [2:0]  err;

    typedef struct packed {
        logic [21:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] file_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_wr = 0;
    logic       prev_req = 1'b0;
    bit         ack_en = 1'b1;
    int         ack_age = 0;

    always #5 clk_sys = ~clk_sys;

    bmp_stream_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .wr_req         (wr_req),
        .wr_ack         (wr_ack),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .loaded         (loaded),
        .img_w          (img_w),
        .img_h          (img_h),
        .err            (err)
    );

    // One cycle of simulation: samples at the falling edge, pops the scoreboard on a
    // wr_req toggle and plays the SDRAM side by returning wr_ack two cycles later.
    task automatic tick;
        wr_t e;
        @(negedge clk_sys);
        if (reset) begin
            prev_req = wr_req;
            wr_ack   = 1'b0;
            ack_age  = 0;
        end else begin
            if (wr_req !== prev_req) begin
                prev_req = wr_req;
                n_wr++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write got addr=%0d data=%h required no write", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (wr_addr !== e.addr || wr_data !== e.data) begin
                        n_bad++;
                        $display("FAIL write_word got addr=%0d data=%h required addr=%0d data=%h",
                                 wr_addr, wr_data, e.addr, e.data);
                    end
                end
            end
            if (ack_en && wr_req !== wr_ack) begin
                ack_age++;
                if (ack_age >= 2) begin
                    wr_ack  = wr_req;
                    ack_age = 0;
                end
            end else begin
                ack_age = 0;
            end
        end
    endtask

    task automatic put32(input int idx, input int v);
        file_q[idx]   = v[7:0];
        file_q[idx+1] = v[15:8];
        file_q[idx+2] = v[23:16];
        file_q[idx+3] = v[31:24];
    endtask

    // Builds a file image and pushes the first n_exp expected words.
    task automatic build(input int w, input int h, input int bpp, input int off,
                         input bit bad_sig, input int n_exp);
        int ah, bpx, pad, k, line, hlen;
        wr_t e;
        logic [7:0] b, g, r, a;
        ah   = (h < 0) ? -h : h;
        bpx  = bpp / 8;
        pad  = (bpp == 24) ? ((4 - (3 * w) % 4) % 4) : 0;
        hlen = (off > 30) ? off : 30;
        k    = 0;
        file_q.delete();
        exp_q.delete();
        for (int i = 0; i < hlen; i++) file_q.push_back(8'h00);
        file_q[0] = 8'h42;
        file_q[1] = bad_sig ? 8'h58 : 8'h4D;
        put32(10, off);
        put32(14, 40);
        put32(18, w);
        put32(22, h);
        file_q[26] = 8'h01;
        file_q[28] = bpp[7:0];
        file_q[29] = bpp[15:8];
        for (int row = 0; row < ah; row++) begin
            for (int c = 0; c < w; c++) begin
                if (k == 0) begin
                    b = 8'h11; g = 8'h22; r = 8'h33; a = 8'h44;
                end else begin
                    b = 8'($urandom); g = 8'($urandom); r = 8'($urandom); a = 8'($urandom);
                end
                file_q.push_back(b);
                file_q.push_back(g);
                file_q.push_back(r);
                if (bpx == 4) file_q.push_back(a);
                if (k < n_exp) begin
                    line   = (h > 0) ? (ah - 1 - row) : row;
                    e.addr = 22'((line << 9) + c);
                    e.data = {(bpx == 4) ? a : 8'h00, r, g, b};
                    exp_q.push_back(e);
                end
                k++;
            end
            for (int p = 0; p < pad; p++) file_q.push_back(8'hEE);
        end
    endtask

    task automatic send_byte(input int i);
        ioctl_addr = 25'(i);
        ioctl_dout = file_q[i];
        ioctl_wr   = 1'b1;
        tick;
        ioctl_wr   = 1'b0;
        tick;
        tick;
    endtask

    task automatic dl_up;
        ioctl_download = 1'b0;
        tick; tick;
        ioctl_download = 1'b1;
        tick; tick;
    endtask

    task automatic dl_down;
        ioctl_download = 1'b0;
        repeat (3) tick;
    endtask

    task automatic send_file(input int n);
        int lim;
        lim = (n < 0 || n > file_q.size()) ? file_q.size() : n;
        n_wr = 0;
        dl_up;
        for (int i = 0; i < lim; i++) send_byte(i);
        repeat (8) tick;
        dl_down;
    endtask

    task automatic expect_done(input string name, input int n_words, input int w, input int h);
        n_cmp++;
        if (n_wr !== n_words || exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL %s_writes got %0d writes (%0d left) required %0d", name, n_wr, exp_q.size(), n_words);
        end
        n_cmp++;
        if (loaded !== 1'b1 || err !== 3'd0) begin
            n_bad++;
            $display("FAIL %s_loaded got loaded=%b err=%0d required loaded=1 err=0", name, loaded, err);
        end
        n_cmp++;
        if (img_w !== 16'(w) || img_h !== 16'(h)) begin
            n_bad++;
            $display("FAIL %s_dims got %0dx%0d required %0dx%0d", name, img_w, img_h, w, h);
        end
    endtask

    task automatic expect_err(input string name, input int code, input int n_words);
        n_cmp++;
        if (err !== 3'(code) || loaded !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_err got err=%0d loaded=%b required err=%0d loaded=0", name, err, loaded, code);
        end
        n_cmp++;
        if (n_wr !== n_words || exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL %s_writes got %0d writes (%0d left) required %0d", name, n_wr, exp_q.size(), n_words);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick;
        reset = 1'b0;
        tick;
        n_cmp++;
        if ({wr_req, wr_addr, wr_data, loaded, img_w, img_h, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_state got req=%b addr=%0d data=%h loaded=%b w=%0d h=%0d err=%0d required all 0",
                     wr_req, wr_addr, wr_data, loaded, img_w, img_h, err);
        end
    endtask

    task automatic test_bottom_up;
        build(4, 2, 24, 54, 1'b0, 8);
        send_file(-1);
        expect_done("bottom_up_4x2", 8, 4, 2);
    endtask

    task automatic test_padding;
        build(3, 1, 24, 54, 1'b0, 3);
        send_file(-1);
        expect_done("pad_3x1", 3, 3, 1);
        build(3, 2, 24, 54, 1'b0, 6);
        send_file(-1);
        expect_done("pad_3x2", 6, 3, 2);
        build(1, 1, 24, 30, 1'b0, 1);
        send_file(-1);
        expect_done("offset30_1x1", 1, 1, 1);
    endtask

    task automatic test_neg_height;
        build(2, -2, 24, 54, 1'b0, 4);
        send_file(-1);
        expect_done("top_down_2x2", 4, 2, 2);
    endtask

    task automatic test_limits;
        build(512, 1, 24, 54, 1'b0, 512);
        send_file(-1);
        expect_done("max_width", 512, 512, 1);
        build(1, -312, 24, 54, 1'b0, 312);
        send_file(-1);
        expect_done("max_height", 312, 1, 312);
    endtask

    task automatic test_header_errors;
        build(600, 2, 24, 54, 1'b0, 0);
        send_file(60);
        expect_err("width_600", 2, 0);
        n_cmp++;
        if (img_w !== 16'd600) begin
            n_bad++;
            $display("FAIL width_600_img_w got %0d required 600", img_w);
        end
        build(4, 2, 24, 54, 1'b1, 0);
        send_file(60);
        expect_err("bad_sig", 1, 0);
        build(4, 0, 24, 54, 1'b0, 0);
        send_file(60);
        expect_err("height_0", 3, 0);
        build(4, 313, 24, 54, 1'b0, 0);
        send_file(60);
        expect_err("height_313", 3, 0);
        build(4, 2, 16, 54, 1'b0, 0);
        send_file(60);
        expect_err("bpp_16", 4, 0);
        build(4, 2, 24, 20, 1'b0, 0);
        send_file(40);
        expect_err("offset_20", 5, 0);
    endtask

    task automatic test_overrun;
        ack_en = 1'b0;
        build(2, 2, 24, 54, 1'b0, 1);
        send_file(-1);
        expect_err("overrun", 6, 1);
        ack_en = 1'b1;
        repeat (4) tick;
        ioctl_download = 1'b1;
        tick; tick;
        n_cmp++;
        if (err !== 3'd0 || loaded !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_clears got err=%0d loaded=%b required err=0 loaded=0", err, loaded);
        end
        dl_down;
        build(1, 1, 24, 30, 1'b0, 1);
        send_file(-1);
        expect_done("after_overrun", 1, 1, 1);
    endtask

    task automatic test_truncated;
        build(4, 4, 24, 54, 1'b0, 13);
        send_file(54 + 40);
        expect_err("truncated", 7, 13);
    endtask

    task automatic test_bpp32;
`ifdef BMP_STREAM_LOADER_ALPHA_EN
        build(2, 1, 32, 54, 1'b0, 2);
        send_file(-1);
        expect_done("alpha_32bpp", 2, 2, 1);
`else
        build(2, 1, 32, 54, 1'b0, 0);
        send_file(60);
        expect_err("no_alpha_32bpp", 4, 0);
`endif
    endtask

    task automatic test_reset_midstream;
        build(4, 2, 24, 54, 1'b0, 2);
        n_wr = 0;
        dl_up;
        for (int i = 0; i < 60; i++) send_byte(i);
        reset = 1'b1;
        tick; tick;
        reset = 1'b0;
        tick;
        for (int i = 60; i < file_q.size(); i++) send_byte(i);
        repeat (5) tick;
        n_cmp++;
        if (n_wr !== 2 || exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL midreset_writes got %0d writes required 2", n_wr);
        end
        n_cmp++;
        if ({loaded, err, img_w, img_h, wr_req} !== '0) begin
            n_bad++;
            $display("FAIL midreset_idle got loaded=%b err=%0d w=%0d h=%0d req=%b required all 0",
                     loaded, err, img_w, img_h, wr_req);
        end
        dl_down;
        build(4, 2, 24, 54, 1'b0, 8);
        send_file(-1);
        expect_done("after_reset", 8, 4, 2);
    endtask

    initial begin
        test_reset;
        test_bottom_up;
        test_padding;
        test_neg_height;
        test_header_errors;
        test_overrun;
        test_truncated;
        test_bpp32;
        test_limits;
        test_reset_midstream;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
